// File: rtl/isa_instr_encoder.sv
// Hardware assembler for the 9-bit two-mode ISA: one request in, one or two machine words out.
// Latency: out_valid rises the cycle after acceptance; a mode-toggle word is inserted ahead when needed.
// Backpressure: words hold on out_valid & !out_ready; in_ready only in IDLE. Optional macro: ENC_TOGGLE_ELIDE_EN.
module isa_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm_mode,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_reg1,
  input  logic [2:0]        in_reg2,
  input  logic [7:0]        in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_code,
  output logic [ADDR_W-1:0] out_addr,
  output logic              mode,
  output logic              err,
  output logic              wrap
);

  typedef enum logic [1:0] {S_IDLE, S_TOGGLE, S_INSTR} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [8:0]          out_code_q, out_code_d;
  logic [8:0]          pend_q, pend_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                mode_q, mode_d;
  logic                err_q, err_d;
  logic                wrap_q, wrap_d;
`ifdef ENC_TOGGLE_ELIDE_EN
  // An accepted explicit toggle held back, waiting to see whether the next request cancels it.
  logic                elide_q, elide_d;
`endif

  logic       imm_ok;
  logic [2:0] imm_idx;
  logic       is_toggle;
  logic       bad_req;
  logic [8:0] instr_word;
  logic       accept;
  logic       consume;

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_addr  = out_addr_q;
  assign mode      = mode_q;
  assign err       = err_q;
  assign wrap      = wrap_q;

  // Map the immediate onto its 3-bit index; anything off the table is unencodable.
  always_comb begin
    imm_ok  = 1'b1;
    imm_idx = 3'd0;
    case (in_imm)
      8'd0:    imm_idx = 3'd0;
      8'd1:    imm_idx = 3'd1;
      8'd4:    imm_idx = 3'd2;
      8'd8:    imm_idx = 3'd3;
      8'd16:   imm_idx = 3'd4;
      8'd32:   imm_idx = 3'd5;
      8'd64:   imm_idx = 3'd6;
      8'd127:  imm_idx = 3'd7;
      default: imm_ok  = 1'b0;
    endcase
  end

  // Encode the request and decide whether it is legal in the mode it asks for.
  always_comb begin
    is_toggle  = (in_opcode == 5'd0);
    instr_word = in_imm_mode ? {in_opcode[2:0], in_reg1, imm_idx}
                             : {in_opcode, in_reg1[1:0], in_reg2[1:0]};
    if (is_toggle)
      bad_req = 1'b0;
    else if (in_imm_mode)
      bad_req = (in_opcode[4:3] != 2'b00) || !imm_ok;
    else
      bad_req = in_reg1[2] || in_reg2[2];
  end

  // Next-state: consume side advances the address/mode, accept side loads new words.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    pend_d      = pend_q;
    out_addr_d  = out_addr_q;
    mode_d      = mode_q;
    err_d       = 1'b0;
    wrap_d      = wrap_q;
`ifdef ENC_TOGGLE_ELIDE_EN
    elide_d     = elide_q;
`endif

    if (consume) begin
      out_addr_d = out_addr_q + 1'b1;
      if (&out_addr_q)
        wrap_d = 1'b1;
      // 9'h000 is only ever produced as a toggle, so consuming it flips the decoder.
      if (out_code_q == 9'h000)
        mode_d = !mode_q;
      if (state_q == S_TOGGLE) begin
        out_code_d = pend_q;
        state_d    = S_INSTR;
      end else begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    end

    // accept only happens in IDLE, where nothing is presented, so it never races consume.
    if (accept) begin
`ifdef ENC_TOGGLE_ELIDE_EN
      elide_d = 1'b0;
      if (bad_req) begin
        err_d = 1'b1;
        // A rejected follower still closes the window: the held toggle goes out alone.
        if (elide_q) begin
          out_code_d  = 9'h000;
          out_valid_d = 1'b1;
          state_d     = S_INSTR;
        end
      end else if (is_toggle) begin
        // A second explicit toggle cancels the held one; otherwise hold this one back.
        elide_d = !elide_q;
      end else if (in_imm_mode == mode_q) begin
        // Either no toggle is held, or the held toggle cancels against the implied one.
        out_code_d  = instr_word;
        out_valid_d = 1'b1;
        state_d     = S_INSTR;
      end else begin
        // A held toggle here is exactly the toggle this request needs.
        out_code_d  = 9'h000;
        pend_d      = instr_word;
        out_valid_d = 1'b1;
        state_d     = S_TOGGLE;
      end
`else
      if (bad_req) begin
        err_d = 1'b1;
      end else if (is_toggle) begin
        out_code_d  = 9'h000;
        out_valid_d = 1'b1;
        state_d     = S_INSTR;
      end else if (in_imm_mode == mode_q) begin
        out_code_d  = instr_word;
        out_valid_d = 1'b1;
        state_d     = S_INSTR;
      end else begin
        out_code_d  = 9'h000;
        pend_d      = instr_word;
        out_valid_d = 1'b1;
        state_d     = S_TOGGLE;
      end
`endif
    end
  end

  // State and registered outputs; reset drops any pending word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_code_q  <= 9'h000;
      pend_q      <= 9'h000;
      out_addr_q  <= '0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
`ifdef ENC_TOGGLE_ELIDE_EN
      elide_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      pend_q      <= pend_d;
      out_addr_q  <= out_addr_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
`ifdef ENC_TOGGLE_ELIDE_EN
      elide_q     <= elide_d;
`endif
    end
  end

endmodule

// File: tb/tb_isa_instr_encoder.sv
// Scoreboard bench for isa_instr_encoder: directed scenarios followed by randomized requests.
// A reference model turns each request into expected words; a monitor pops and compares on consume.
// out_ready is randomized or forced by the main sequence.
module tb_isa_instr_encoder;
  localparam int AW = 2;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_imm_mode;
  logic [4:0]    in_opcode;
  logic [2:0]    in_reg1;
  logic [2:0]    in_reg2;
  logic [7:0]    in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    out_code;
  logic [AW-1:0] out_addr;
  logic          mode;
  logic          err;
  logic          wrap;

  always #5 clk = ~clk;

  isa_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm_mode(in_imm_mode),
    .in_opcode(in_opcode), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_addr(out_addr), .mode(mode), .err(err), .wrap(wrap)
  );

  typedef struct {
    int code;
    int addr;
    bit mode;
    bit wrap;
    bit chained;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_ctrl = 1;
  bit   mon_en = 0;
  bit   m_mode;
  int   m_addr;
  bit   m_wrap;
  int   legal_imm[8] = '{0, 1, 4, 8, 16, 32, 64, 127};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int imm_index(input int imm);
    for (int i = 0; i < 8; i++)
      if (legal_imm[i] == imm) return i;
    return -1;
  endfunction

  // Record one word the DUT must emit, with the mode/wrap visible while it is presented.
  task automatic push_word(input int code, input bit chained);
    exp_t e;
    e.code = code; e.addr = m_addr; e.mode = m_mode; e.wrap = m_wrap; e.chained = chained;
    sb.push_back(e);
    if (m_addr == AMOD - 1) m_wrap = 1;
    m_addr = (m_addr + 1) % AMOD;
    if (code == 0) m_mode = !m_mode;
  endtask

  // Reference model: word formats from the ISA rules with plain arithmetic.
  task automatic model_req(input bit im, input int opc, input int r1, input int r2,
                           input int imm, output bit rej);
    int idx;
    int word;
    idx = imm_index(imm);
    rej = 0;
    if (opc == 0) begin
      push_word(0, 0);
    end else if (im ? (opc >= 8 || idx < 0) : (r1 >= 4 || r2 >= 4)) begin
      rej = 1;
    end else begin
      word = im ? (opc % 8) * 64 + r1 * 8 + idx : opc * 16 + r1 * 4 + r2;
      if (im != m_mode) push_word(0, 1);
      push_word(word, 0);
    end
  endtask

  task automatic issue(input bit im, input int opc, input int r1, input int r2, input int imm);
    int waited;
    bit rej;
    waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1; in_imm_mode = im; in_opcode = opc[4:0];
    in_reg1 = r1[2:0]; in_reg2 = r2[2:0]; in_imm = imm[7:0];
    model_req(im, opc, r1, r2, imm, rej);
    @(posedge clk);
    #1;
    in_valid = 0;
    check("err_pulse", err, rej);
    check("valid_latency", out_valid, !rej);
    if (rej) begin
      @(posedge clk);
      #1;
      check("err_clear", err, 0);
      check("rej_no_word", out_valid, 0);
      check("rej_addr_hold", out_addr, m_addr);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid !== 1'b0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", t < 500, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    sb.delete();
    m_mode = 0; m_addr = 0; m_wrap = 0;
    @(negedge clk);
    reset = 0;
  endtask

  // out_ready: random when rdy_ctrl < 0, else forced to rdy_ctrl.
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_ctrl < 0) out_ready = ($urandom % 4) != 0;
      else out_ready = rdy_ctrl[0];
    end
  end

  // Monitor: compare every consumed word against the scoreboard, plus hold and no-bubble rules.
  initial begin
    bit         hold_pend;
    bit         chain_pend;
    logic [8:0] hold_code;
    logic [AW-1:0] hold_addr;
    hold_pend = 0; chain_pend = 0; hold_code = '0; hold_addr = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        check("in_ready_idle", in_ready, !out_valid);
        if (hold_pend) begin
          check("hold_valid", out_valid, 1);
          check("hold_code", out_code, hold_code);
          check("hold_addr", out_addr, hold_addr);
          hold_pend = 0;
        end
        if (chain_pend) begin
          check("no_bubble", out_valid, 1);
          chain_pend = 0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got code %0h at addr %0d, none expected", out_code, out_addr);
          end else begin
            mon_e = sb.pop_front();
            check("word_code", out_code, mon_e.code);
            check("word_addr", out_addr, mon_e.addr);
            check("word_mode", mode, mon_e.mode);
            check("word_wrap", wrap, mon_e.wrap);
            chain_pend = mon_e.chained;
          end
        end else if (out_valid) begin
          hold_pend = 1;
          hold_code = out_code;
          hold_addr = out_addr;
        end
      end else begin
        hold_pend = 0;
        chain_pend = 0;
      end
    end
  end

  initial begin
    bit im;
    int opc, r1, r2, imm;
    reset = 1; in_valid = 0; in_imm_mode = 0; in_opcode = 0;
    in_reg1 = 0; in_reg2 = 0; in_imm = 0;
    m_mode = 0; m_addr = 0; m_wrap = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_mode", mode, 0);
    check("rst_err", err, 0);
    check("rst_wrap", wrap, 0);
    reset = 0;
    mon_en = 1;

    // Reg-reg word in matching mode.
    rdy_ctrl = 1;
    issue(0, 5, 2, 3, 0);
    drain();
    check("rr_mode_stays", mode, 0);

    // Reg-imm from mode 0 inserts a toggle.
    do_reset();
    issue(1, 3, 5, 0, 16);
    drain();
    check("ri_mode_after", mode, 1);

    // Rejections: unencodable immediate, high register bit.
    issue(1, 3, 1, 0, 5);
    issue(0, 2, 4, 1, 0);
    check("rej_mode_kept", mode, m_mode);

    // Stall during TOGGLE: toggle word holds, instruction follows without a gap.
    do_reset();
    rdy_ctrl = 0;
    issue(1, 3, 5, 0, 16);
    repeat (3) begin
      @(negedge clk);
      check("stall_code", out_code, 0);
      check("stall_in_ready", in_ready, 0);
    end
    rdy_ctrl = 1;
    drain();

    // Five words from reset: addresses 0,1,2,3,0 and sticky wrap.
    do_reset();
    for (int i = 0; i < 5; i++) issue(0, i + 1, i % 4, 3 - (i % 4), 0);
    drain();
    check("wrap_sticky", wrap, 1);

    // Explicit toggle request.
    issue(0, 0, 0, 0, 0);
    drain();
    check("explicit_toggle_mode", mode, m_mode);

    // Reset while the toggle word is presented drops the pending word.
    do_reset();
    issue(1, 2, 3, 0, 64);
    issue(1, 1, 7, 0, 127);
    drain();
    rdy_ctrl = 0;
    issue(0, 9, 1, 2, 0);
    #2;
    reset = 1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_mode", mode, 0);
    check("midrst_addr", out_addr, 0);
    sb.delete();
    m_mode = 0; m_addr = 0; m_wrap = 0;
    @(negedge clk);
    reset = 0;
    rdy_ctrl = 1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_pending", out_valid, 0);
    end

    // Randomized traffic with random backpressure.
    rdy_ctrl = -1;
    for (int n = 0; n < 300; n++) begin
      im  = $urandom % 2;
      if ($urandom % 10 == 0) opc = 0;
      else if (im) opc = ($urandom % 6 == 0) ? $urandom_range(8, 31) : $urandom_range(1, 7);
      else opc = $urandom_range(1, 31);
      r1  = im ? $urandom_range(0, 7) : (($urandom % 8 == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3));
      r2  = ($urandom % 8 == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      imm = ($urandom % 8 == 0) ? $urandom_range(0, 255) : legal_imm[$urandom % 8];
      issue(im, opc, r1, r2, imm);
    end
    drain();
    check("final_mode", mode, m_mode);
    check("final_addr", out_addr, m_addr);
    check("final_wrap", wrap, m_wrap);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
